// File: rtl/hamming_enc_arbiter.sv
// Round-robin arbiter feeding one shared Hamming(15,11) encoder; the encoded word
// is held on a valid/ready port, tagged with the requester index.
module hamming_enc_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [11*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 cw_valid,
    output logic [14:0]          cw_data,
    output logic [ID_W-1:0]      cw_id,
    input  logic                 cw_ready,
    input  logic [3:0]           err_inj_pos,
    output logic                 busy,
    output logic [15:0]          words_sent
);

    // Output port handshake: a codeword transfers on a cycle where cw_valid and
    // cw_ready are both high; cw_valid, cw_data and cw_id stay stable until then.
    typedef enum logic [1:0] {IDLE, ENC, OUT} state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] last_q, last_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [10:0]     data_q, data_d;
    logic            cw_valid_q, cw_valid_d;
    logic [14:0]     cw_data_q, cw_data_d;
    logic [ID_W-1:0] cw_id_q, cw_id_d;
    logic [15:0]     words_q, words_d;

    logic            grant_found;
    logic [ID_W-1:0] winner;
    int              idx;
    logic [14:0]     inj_mask;

    function automatic logic [14:0] encode(input logic [10:0] d);
        logic [14:0] cw;
        cw       = '0;
        cw[14:8] = d[10:4];
        cw[6:4]  = d[3:1];
        cw[2]    = d[0];
        cw[0]    = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10];
        cw[1]    = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[10];
        cw[3]    = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[10];
        cw[7]    = ^d[10:4];
        return cw;
    endfunction

    // Scan starts one past the last winner so a held request waits its turn.
    always_comb begin
        grant_found = 1'b0;
        winner      = '0;
        idx         = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(last_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                winner      = idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && grant_found) req_ready[winner] = 1'b1;
    end

    assign inj_mask = (err_inj_pos == 4'd0) ? 15'd0 : (15'd1 << (err_inj_pos - 4'd1));

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        id_d       = id_q;
        data_d     = data_q;
        cw_valid_d = cw_valid_q;
        cw_data_d  = cw_data_q;
        cw_id_d    = cw_id_q;
        words_d    = words_q;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    data_d  = req_data[11*int'(winner) +: 11];
                    id_d    = winner;
                    last_d  = winner;
                    state_d = ENC;
                end
            end
            ENC: begin
                cw_data_d  = encode(data_q) ^ inj_mask;
                cw_id_d    = id_q;
                cw_valid_d = 1'b1;
                state_d    = OUT;
            end
            OUT: begin
                if (cw_ready) begin
                    cw_valid_d = 1'b0;
                    words_d    = words_q + 16'd1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= ID_W'(NUM_REQ - 1);
            id_q       <= '0;
            data_q     <= '0;
            cw_valid_q <= 1'b0;
            cw_data_q  <= '0;
            cw_id_q    <= '0;
            words_q    <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            id_q       <= id_d;
            data_q     <= data_d;
            cw_valid_q <= cw_valid_d;
            cw_data_q  <= cw_data_d;
            cw_id_q    <= cw_id_d;
            words_q    <= words_d;
        end
    end

    assign cw_valid   = cw_valid_q;
    assign cw_data    = cw_data_q;
    assign cw_id      = cw_id_q;
    assign busy       = (state_q != IDLE);
    assign words_sent = words_q;

endmodule

// File: tb/tb_hamming_enc_arbiter.sv
// Bench for hamming_enc_arbiter: directed and randomized transactions against a
// positional Hamming model and a round-robin model kept here.
module tb_hamming_enc_arbiter;
    localparam int N    = 4;
    localparam int ID_W = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [N-1:0]       req_valid;
    logic [11*N-1:0]    req_data;
    logic [N-1:0]       req_ready;
    logic               cw_valid;
    logic [14:0]        cw_data;
    logic [ID_W-1:0]    cw_id;
    logic               cw_ready;
    logic [3:0]         err_inj_pos;
    logic               busy;
    logic [15:0]        words_sent;

    int errors = 0;
    int checks = 0;
    int model_last = N - 1;
    int model_sent = 0;
    logic [10:0] words [N];

    hamming_enc_arbiter #(.NUM_REQ(N), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .cw_valid(cw_valid), .cw_data(cw_data),
        .cw_id(cw_id), .cw_ready(cw_ready), .err_inj_pos(err_inj_pos),
        .busy(busy), .words_sent(words_sent)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Codeword position p (1..15) is bit p-1; powers of two hold parity,
    // the rest carry data bits in ascending order.
    function automatic logic [14:0] ref_encode(input logic [10:0] d, input logic [3:0] pos);
        logic [14:0] cw;
        logic        par;
        int          k;
        int          pp;
        cw = '0;
        k  = 0;
        for (int p = 1; p <= 15; p++) begin
            if ((p & (p - 1)) != 0) begin
                cw[p-1] = d[k];
                k++;
            end
        end
        for (int b = 0; b < 4; b++) begin
            pp  = 1 << b;
            par = 1'b0;
            for (int p = 1; p <= 15; p++) if ((p & pp) != 0) par = par ^ cw[p-1];
            cw[pp-1] = par;
        end
        if (pos != 4'd0) cw[pos-1] = ~cw[pos-1];
        return cw;
    endfunction

    function automatic int ref_pick(input logic [N-1:0] v);
        int i;
        for (int k = 1; k <= N; k++) begin
            i = (model_last + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic drive_words();
        for (int i = 0; i < N; i++) req_data[11*i +: 11] = words[i];
    endtask

    task automatic randomize_words();
        for (int i = 0; i < N; i++) words[i] = 11'($urandom_range(0, 2047));
        drive_words();
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
        model_last = N - 1;
        model_sent = 0;
    endtask

    // Called at posedge+1 with the DUT idle; runs one word through the pipeline.
    task automatic run_txn(input logic [N-1:0] valids, input logic [3:0] pos, input int stall,
                           input bit abort, output logic [14:0] obs, output int w);
        logic [14:0] exp_cw;
        w      = ref_pick(valids);
        exp_cw = ref_encode(words[w], pos);
        req_valid   = valids;
        cw_ready    = 1'($urandom_range(0, 1));
        err_inj_pos = 4'($urandom_range(0, 15));
        #1;
        chk("idle_req_ready", 32'(req_ready), 32'(1 << w));
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_cw_valid", 32'(cw_valid), 32'd0);
        @(posedge clk); #1;
        model_last = w;
        req_valid   = N'($urandom_range(0, 15));
        randomize_words();
        err_inj_pos = pos;
        cw_ready    = 1'($urandom_range(0, 1));
        #1;
        chk("enc_req_ready", 32'(req_ready), 32'd0);
        chk("enc_busy", 32'(busy), 32'd1);
        chk("enc_cw_valid", 32'(cw_valid), 32'd0);
        @(posedge clk); #1;
        err_inj_pos = 4'($urandom_range(0, 15));
        cw_ready    = 1'b0;
        obs = cw_data;
        for (int s = 0; s <= stall; s++) begin
            if (s > 0) begin
                @(posedge clk); #1;
                err_inj_pos = 4'($urandom_range(0, 15));
            end
            chk("out_cw_valid", 32'(cw_valid), 32'd1);
            chk("out_cw_data", 32'(cw_data), 32'(exp_cw));
            chk("out_cw_id", 32'(cw_id), 32'(w));
            chk("out_req_ready", 32'(req_ready), 32'd0);
            chk("out_busy", 32'(busy), 32'd1);
        end
        if (abort) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            model_last = N - 1;
            model_sent = 0;
            chk("rst_cw_valid", 32'(cw_valid), 32'd0);
            chk("rst_cw_data", 32'(cw_data), 32'd0);
            chk("rst_cw_id", 32'(cw_id), 32'd0);
        end else begin
            cw_ready = 1'b1;
            @(posedge clk); #1;
            model_sent++;
            chk("hs_cw_valid", 32'(cw_valid), 32'd0);
        end
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_words_sent", 32'(words_sent), 32'(model_sent));
    endtask

    initial begin
        logic [14:0] obs;
        int          w;
        logic [10:0] vec_in  [3];
        logic [14:0] vec_out [3];
        vec_in[0] = 11'h000; vec_out[0] = 15'h0000;
        vec_in[1] = 11'h7FF; vec_out[1] = 15'h7FFF;
        vec_in[2] = 11'h400; vec_out[2] = 15'h408B;

        req_valid = '0; req_data = '0; cw_ready = 1'b0; err_inj_pos = '0;
        for (int i = 0; i < N; i++) words[i] = '0;
        do_reset(3);
        chk("reset_cw_valid", 32'(cw_valid), 32'd0);
        chk("reset_cw_data", 32'(cw_data), 32'd0);
        chk("reset_cw_id", 32'(cw_id), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_words_sent", 32'(words_sent), 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd0);

        // Single requester: basic word, then encoding vectors back to back.
        words[0] = 11'h001; drive_words();
        run_txn(4'b0001, 4'd0, 0, 1'b0, obs, w);
        chk("t1_cw_data", 32'(obs), 32'h0007);
        chk("t1_words_sent", 32'(words_sent), 32'd1);
        for (int v = 0; v < 3; v++) begin
            words[0] = vec_in[v]; drive_words();
            run_txn(4'b0001, 4'd0, 0, 1'b0, obs, w);
            chk("vec_cw_data", 32'(obs), 32'(vec_out[v]));
            chk("vec_grant", 32'(w), 32'd0);
        end

        // All requesters valid from reset: strict rotation.
        do_reset(2);
        for (int g = 0; g < 5; g++) begin
            randomize_words();
            run_txn(4'b1111, 4'd0, 0, 1'b0, obs, w);
            chk("rr_grant", 32'(w), 32'(g % N));
        end

        // Backpressure for 10 cycles.
        randomize_words();
        run_txn(4'b0110, 4'd0, 10, 1'b0, obs, w);

        // Error injection sampled in ENC only.
        words[0] = 11'h000; drive_words();
        run_txn(4'b0001, 4'd5, 0, 1'b0, obs, w);
        chk("inj5_cw_data", 32'(obs), 32'h0010);
        words[0] = 11'h000; drive_words();
        run_txn(4'b0001, 4'd0, 0, 1'b0, obs, w);
        chk("inj0_cw_data", 32'(obs), 32'h0000);

        // Reset while holding a codeword, then priority returns to requester 0.
        randomize_words();
        run_txn(4'b0100, 4'd0, 3, 1'b1, obs, w);
        randomize_words();
        run_txn(4'b1111, 4'd0, 0, 1'b0, obs, w);
        chk("post_rst_grant", 32'(w), 32'd0);

        // Randomized traffic.
        for (int t = 0; t < 60; t++) begin
            randomize_words();
            run_txn(N'($urandom_range(1, 15)), 4'($urandom_range(0, 15)),
                    $urandom_range(0, 3), 1'b0, obs, w);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
